imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning word-index width, so capacity is 2^ADDR_WIDTH instruction words.
REQ-002 The block SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port rx_valid  input  1  upstream byte valid.
REQ-005 The block SHALL have port rx_data  input  8  upstream byte.
REQ-006 The block SHALL have port rx_ready  output  1  loader can accept a byte this cycle.
REQ-007 The block SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-008 The block SHALL have port imem_addr  output  32  byte address of the write, word-aligned.
REQ-009 The block SHALL have port imem_wdata  output  32  instruction word to write.
REQ-010 The block SHALL have port cpu_reset  output  1  reset to the CPU; high while loading.
REQ-011 The block SHALL have port done  output  1  program fully loaded.
REQ-012 The block SHALL have port error  output  1  header word count exceeds capacity.

Function
REQ-013 The block SHALL accept a byte only on a rising edge where rx_valid and rx_ready are both 1; rx_valid low cycles (gaps) SHALL be tolerated with no state change.
REQ-014 The stream format SHALL be a 16-bit word count N (high byte, then low byte), followed by N instruction words, each sent as 4 bytes, MSB first.
REQ-015 FSM states SHALL be HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR; all outputs registered or decoded from state only.
REQ-016 HDR_HI: rx_ready=1; on accept, store the high count byte and go to HDR_LO.
REQ-017 HDR_LO: rx_ready=1; on accept, form N; N=0 -> DONE; N > 2^ADDR_WIDTH -> ERROR; otherwise clear the word index and byte counter and go to DATA.
REQ-018 DATA: rx_ready=1; each accepted byte SHALL shift into the word assembly register (new byte into bits 7:0); on the 4th byte go to WRITE.
REQ-019 WRITE SHALL last exactly one cycle with rx_ready=0, imem_we=1, imem_addr={word_index,2'b00} zero-extended to 32 bits, and imem_wdata equal to the assembled word.
REQ-020 After WRITE, the block SHALL increment the word index and go to DONE if the index+1 equals N, else go to DATA.
REQ-021 DONE: rx_ready=0, imem_we=0, done=1, cpu_reset=0; the block SHALL hold this state until reset.
REQ-022 ERROR: rx_ready=0, imem_we=0, error=1, cpu_reset=1, done=0; the block SHALL hold this state until reset.
REQ-023 cpu_reset SHALL be 1 in every state except DONE, so the CPU never fetches a partially loaded program.
REQ-024 imem_we SHALL be 0 in every state except WRITE; exactly N write strobes SHALL occur per load.
REQ-025 The word-index counter SHALL be ADDR_WIDTH+1 bits wide so that N = 2^ADDR_WIDTH completes without wrap-around.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL go to HDR_HI and clear all counters and the assembly register, with rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0.
REQ-027 Reset mid-load (any state) SHALL abandon the load; the next byte accepted SHALL be treated as a header high byte, and already-written words SHALL not be rewritten.

Verification
REQ-028 The stream 00 02 20 08 00 06 20 09 00 0B with rx_valid held high SHALL produce a write of 0x20080006 to address 0, then a write of 0x2009000B to address 4; cpu_reset SHALL fall and done SHALL rise on the cycle after the second WRITE.
REQ-029 The same stream with rx_valid low for 3 cycles between every byte SHALL produce identical writes and a final state of done=1.
REQ-030 The header 00 00 SHALL produce no imem_we pulse, with done=1 and cpu_reset=0 on the cycle after the low byte is accepted.
REQ-031 With ADDR_WIDTH=8, the header 01 2C (N=300) SHALL produce error=1, rx_ready=0, cpu_reset=1, and no writes; a following reset SHALL clear error.
REQ-032 With ADDR_WIDTH=2 and the header 00 04 followed by 4 words, the last write SHALL go to address 12, then done=1.
REQ-033 Asserting reset after 6 bytes of a 2-word load, then sending a full 1-word stream 00 01 8C 08 00 04, SHALL produce a single write of 0x8C080004 to address 0, then done=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream and writes it into
// instruction memory. The CPU is held in reset until the whole image is loaded.
//
// Stream format: a 16-bit word count N (high byte first), then N instruction
// words of 4 bytes each, MSB first.
//
// Ports
//   clock       single system clock; all state updates on its rising edge
//   reset       synchronous, active-high reset
//   rx_valid    upstream byte valid
//   rx_data     upstream byte
//   rx_ready    loader can accept a byte this cycle
//   imem_we     instruction-memory write strobe (one cycle per word)
//   imem_addr   byte address of the write, word-aligned
//   imem_wdata  instruction word to write
//   cpu_reset   reset to the CPU; high in every state except DONE
//   done        program fully loaded
//   error       header word count exceeds capacity
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  // One extra index bit so a full-capacity load can count up to 2^ADDR_WIDTH.
  localparam int unsigned IdxW = ADDR_WIDTH + 1;
  localparam logic [31:0] Capacity = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StHdrHi,
    StHdrLo,
    StData,
    StWrite,
    StDone,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [15:0]       count_q, count_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;

  logic              accept;
  logic [15:0]       hdr_count;
  logic [IdxW-1:0]   idx_inc;

  assign accept    = rx_valid && rx_ready;
  assign hdr_count = {hdr_hi_q, rx_data};
  assign idx_inc   = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StHdrHi;
      hdr_hi_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      hdr_hi_q   <= hdr_hi_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    hdr_hi_d   = hdr_hi_q;
    count_d    = count_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;

    unique case (state_q)
      StHdrHi: begin
        if (accept) begin
          hdr_hi_d = rx_data;
          state_d  = StHdrLo;
        end
      end

      StHdrLo: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count == 16'd0) begin
            state_d = StDone;
          end else if (32'(hdr_count) > Capacity) begin
            state_d = StError;
          end else begin
            idx_d      = '0;
            byte_cnt_d = '0;
            state_d    = StData;
          end
        end
      end

      StData: begin
        if (accept) begin
          word_d     = {word_q[23:0], rx_data};
          // Two-bit counter wraps back to 0 after the 4th byte, ready for the next word.
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        idx_d   = idx_inc;
        state_d = (32'(idx_inc) == 32'(count_q)) ? StDone : StData;
      end

      StDone, StError: begin
        // Terminal until reset.
      end

      default: begin
        state_d = StHdrHi;
      end
    endcase
  end

  // Outputs decoded from state and registered datapath only.
  always_comb begin
    rx_ready   = 1'b0;
    imem_we    = 1'b0;
    cpu_reset  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    imem_addr  = 32'({idx_q, 2'b00});
    imem_wdata = word_q;

    unique case (state_q)
      StHdrHi, StHdrLo, StData: rx_ready = 1'b1;
      StWrite:                  imem_we  = 1'b1;
      StDone: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      StError:                  error    = 1'b1;
      default: begin
        // Safe defaults already applied.
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader. Two instances are exercised
// (ADDR_WIDTH 8 and 2) so both the large-count error and the full-capacity
// boundary are reachable. Expected writes come from a byte-stream model.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef logic [63:0] wq_t[$];
  typedef struct {
    int          s;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       reset;
  logic [1:0]       rx_valid;
  logic [1:0][7:0]  rx_data;
  logic [1:0]       rx_ready;
  logic [1:0]       imem_we;
  logic [1:0][31:0] imem_addr;
  logic [1:0][31:0] imem_wdata;
  logic [1:0]       cpu_reset;
  logic [1:0]       done;
  logic [1:0]       error;

  imem_loader #(.ADDR_WIDTH(8)) u_dut_a8 (
    .clock      (clock),
    .reset      (reset[0]),
    .rx_valid   (rx_valid[0]),
    .rx_data    (rx_data[0]),
    .rx_ready   (rx_ready[0]),
    .imem_we    (imem_we[0]),
    .imem_addr  (imem_addr[0]),
    .imem_wdata (imem_wdata[0]),
    .cpu_reset  (cpu_reset[0]),
    .done       (done[0]),
    .error      (error[0])
  );

  imem_loader #(.ADDR_WIDTH(2)) u_dut_a2 (
    .clock      (clock),
    .reset      (reset[1]),
    .rx_valid   (rx_valid[1]),
    .rx_data    (rx_data[1]),
    .rx_ready   (rx_ready[1]),
    .imem_we    (imem_we[1]),
    .imem_addr  (imem_addr[1]),
    .imem_wdata (imem_wdata[1]),
    .cpu_reset  (cpu_reset[1]),
    .done       (done[1]),
    .error      (error[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cap_of(input int s);
    return (s == 0) ? 256 : 4;
  endfunction

  // Monitor: log writes and track invariants per instance.
  int  cyc = 0;
  wr_t wr_log[$];
  int  last_we_cyc[2];
  int  done_cyc[2];
  int  viol[2];
  logic [1:0] prev_done = 2'b00;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (reset[s]) begin
        viol[s]        <= 0;
        done_cyc[s]    <= -1;
        last_we_cyc[s] <= -1;
      end else begin
        if (imem_we[s]) begin
          wr_log.push_back('{s: s, addr: imem_addr[s], data: imem_wdata[s]});
          last_we_cyc[s] <= cyc;
        end
        if (done[s] && !prev_done[s]) done_cyc[s] <= cyc;
        if ((cpu_reset[s] == done[s]) || (done[s] && error[s]) ||
            (imem_we[s] && (rx_ready[s] || done[s] || error[s])))
          viol[s] <= viol[s] + 1;
      end
      prev_done[s] <= done[s];
    end
  end

  // Reference: decode a byte stream into the writes a correct loader makes.
  function automatic void model(input bq_t b, input int cap, output wq_t wq,
                                output bit exp_done, output bit exp_err);
    int n;
    wq       = {};
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'(b[0]) * 256 + int'(b[1]);
    if (n == 0) begin
      exp_done = 1'b1;
    end else if (n > cap) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < n; w++) begin
        logic [31:0] word;
        word = {b[2 + 4*w], b[3 + 4*w], b[4 + 4*w], b[5 + 4*w]};
        wq.push_back({32'(w * 4), word});
      end
      exp_done = 1'b1;
    end
  endfunction

  task automatic do_reset(input int s);
    @(negedge clock);
    reset[s]    = 1'b1;
    rx_valid[s] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset[s] = 1'b0;
    check_eq("rst_rx_ready",  rx_ready[s],   1);
    check_eq("rst_imem_we",   imem_we[s],    0);
    check_eq("rst_imem_addr", imem_addr[s],  0);
    check_eq("rst_wdata",     imem_wdata[s], 0);
    check_eq("rst_cpu_reset", cpu_reset[s],  1);
    check_eq("rst_done",      done[s],       0);
    check_eq("rst_error",     error[s],      0);
  endtask

  // Present one byte; returns once a rising edge has accepted it.
  task automatic send_byte(input int s, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      rx_valid[s] = 1'b1;
      rx_data[s]  = b;
      if (rx_ready[s]) begin
        @(posedge clock);
        ok = 1'b1;
        break;
      end
    end
  endtask

  // gap < 0 selects a random 0..3 idle cycles after each byte.
  task automatic run_load(input int s, input bq_t bytes, input int gap);
    int  mark;
    int  k;
    bit  ok;
    bit  exp_done;
    bit  exp_err;
    wq_t exp_wr;
    mark = wr_log.size();
    foreach (bytes[i]) begin
      int g;
      send_byte(s, bytes[i], ok);
      if (!ok) begin
        check_eq("accept_timeout", 0, 1);
        break;
      end
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int j = 0; j < g; j++) begin
        @(negedge clock);
        rx_valid[s] = 1'b0;
      end
    end
    @(negedge clock);
    rx_valid[s] = 1'b0;
    repeat (4) @(negedge clock);

    model(bytes, cap_of(s), exp_wr, exp_done, exp_err);
    k = 0;
    for (int i = mark; i < wr_log.size(); i++) begin
      if (wr_log[i].s == s) begin
        if (k < exp_wr.size()) begin
          check_eq("wr_addr", wr_log[i].addr, exp_wr[k][63:32]);
          check_eq("wr_data", wr_log[i].data, exp_wr[k][31:0]);
        end
        k++;
      end
    end
    check_eq("wr_count",  k,            exp_wr.size());
    check_eq("done",      done[s],      exp_done);
    check_eq("error",     error[s],     exp_err);
    check_eq("cpu_reset", cpu_reset[s], !exp_done);
    check_eq("rx_ready",  rx_ready[s],  0);
    check_eq("invariant", viol[s],      0);
    if (exp_done && exp_wr.size() > 0)
      check_eq("done_latency", 64'(done_cyc[s] - last_we_cyc[s]), 1);
  endtask

  function automatic bq_t make_stream(input int n, input bit hdr_only);
    bq_t b;
    b = {};
    b.push_back(8'(n >> 8));
    b.push_back(8'(n));
    if (!hdr_only)
      for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  initial begin
    bq_t b;
    bit  ok;
    reset    = 2'b11;
    rx_valid = 2'b00;
    rx_data  = '0;
    do_reset(0);
    do_reset(1);

    // Two-word load, back to back, then with 3-cycle gaps.
    b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h06, 8'h20, 8'h09, 8'h00, 8'h0B};
    run_load(0, b, 0);
    do_reset(0);
    run_load(0, b, 3);

    // Empty program.
    do_reset(0);
    run_load(0, '{8'h00, 8'h00}, 0);

    // Over capacity (N=300), then reset clears the error.
    do_reset(0);
    run_load(0, '{8'h01, 8'h2C}, 0);
    do_reset(0);

    // Full capacity and one past it on the 2-bit instance.
    run_load(1, make_stream(4, 1'b0), -1);
    do_reset(1);
    run_load(1, make_stream(5, 1'b1), 0);
    do_reset(1);

    // Reset mid-load, then a fresh one-word stream.
    b = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (b[i]) begin
      send_byte(0, b[i], ok);
      if (!ok) check_eq("accept_timeout", 0, 1);
    end
    do_reset(0);
    run_load(0, '{8'h00, 8'h01, 8'h8C, 8'h08, 8'h00, 8'h04}, 0);

    // Randomized loads on both instances.
    for (int t = 0; t < 24; t++) begin
      int s;
      int n;
      s = t % 2;
      do_reset(s);
      if (s == 1) n = int'($urandom_range(0, 5));
      else if ($urandom_range(0, 7) == 0) n = int'($urandom_range(257, 1000));
      else n = int'($urandom_range(0, 12));
      run_load(s, make_stream(n, n > cap_of(s)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
